// File: rtl/ccta_pkg.sv
// Shared encodings for the CCTA arbiter slice: FSM states, opcodes and requester IDs.
// Every ccta_* file imports this package.
package ccta_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Requester 0 wins unless requester 1 is alone or requester 0 was served last.
    function automatic logic pick_r0(logic v0, logic v1, logic last);
        return v0 && (!v1 || last == REQ1);
    endfunction

endpackage

// File: rtl/ccta_alu.sv
// Shared add/subtract datapath. Operands are zero-extended, so subtraction wraps
// modulo 2^(W+1).
module ccta_alu
    import ccta_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   q
);

    logic [W:0] a_ext;
    logic [W:0] b_ext;

    assign a_ext = {1'b0, a};
    assign b_ext = {1'b0, b};

    always_comb begin
        q = a_ext + b_ext;
        if (op == OP_SUB) begin
            q = a_ext - b_ext;
        end
    end

endmodule

// File: rtl/ccta_arb.sv
// Round-robin arbiter and sequencer sharing one ccta_alu between two requesters.
// IDLE accepts one request, EXEC registers the result, DONE holds it until consumed.
module ccta_arb
    import ccta_pkg::*;
#(
    parameter int unsigned W    = 4,
    parameter int unsigned CNTW = 8
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            r0_valid,
    output logic            r0_ready,
    input  logic            r0_op,
    input  logic [W-1:0]    r0_a,
    input  logic [W-1:0]    r0_b,

    input  logic            r1_valid,
    output logic            r1_ready,
    input  logic            r1_op,
    input  logic [W-1:0]    r1_a,
    input  logic [W-1:0]    r1_b,

    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_id,
    output logic [W:0]      res_q,

    output logic            busy,
    output logic [CNTW-1:0] op_cnt
);

    state_e         state;
    logic           last;
    logic           op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           id_q;
    logic [W:0]     alu_q;
    logic           gnt0;
    logic           gnt1;

    assign gnt0 = pick_r0(r0_valid, r1_valid, last);
    assign gnt1 = r1_valid && !gnt0;

    // Readies are gated by rst_n so they read 0 while reset is held, whatever the valids do.
    assign r0_ready = rst_n && (state == StIdle) && gnt0;
    assign r1_ready = rst_n && (state == StIdle) && gnt1;
    assign busy     = (state != StIdle);

    ccta_alu #(
        .W (W)
    ) u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .q  (alu_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            last      <= REQ1;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= REQ0;
            res_valid <= 1'b0;
            res_id    <= REQ0;
            res_q     <= '0;
            op_cnt    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (gnt0) begin
                        op_q  <= r0_op;
                        a_q   <= r0_a;
                        b_q   <= r0_b;
                        id_q  <= REQ0;
                        state <= StExec;
                    end else if (gnt1) begin
                        op_q  <= r1_op;
                        a_q   <= r1_a;
                        b_q   <= r1_b;
                        id_q  <= REQ1;
                        state <= StExec;
                    end
                end
                StExec: begin
                    res_q     <= alu_q;
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= StDone;
                end
                StDone: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        op_cnt    <= op_cnt + 1'b1;
                        last      <= res_id;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ccta_arb.sv
// Scoreboard bench for ccta_arb: queued requests per requester, a cycle model of the
// handshake and pointer, and expected results popped when the DUT hands a result over.
module tb_ccta_arb;
    import ccta_pkg::*;

    typedef struct packed {
        logic       op;
        logic [3:0] a;
        logic [3:0] b;
    } req_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       r0_valid = 1'b0, r0_op = 1'b0, r1_valid = 1'b0, r1_op = 1'b0;
    logic [3:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic       r0_ready, r1_ready, res_valid, res_id, busy;
    logic       res_ready = 1'b0;
    logic [4:0] res_q;
    logic [7:0] op_cnt;

    req_t       rq0[$];
    req_t       rq1[$];
    logic [5:0] sb[$];
    logic       glog[$];

    int         n_checks = 0;
    int         n_fail = 0;
    logic       m_busy = 1'b0;
    logic       m_last = 1'b1;
    int         m_age = 0;
    logic [7:0] m_cnt = '0;
    logic       acc0 = 1'b0, acc1 = 1'b0, drv_en = 1'b0;
    logic [4:0] last_q = '0;
    logic       last_id = 1'b0;

    ccta_arb #(
        .W    (4),
        .CNTW (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_op     (r0_op),
        .r0_a      (r0_a),
        .r0_b      (r0_b),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_op     (r1_op),
        .r1_a      (r1_a),
        .r1_b      (r1_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_q     (res_q),
        .busy      (busy),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [4:0] exp_res(input logic op, input logic [3:0] a,
                                           input logic [3:0] b);
        logic [4:0] ax;
        logic [4:0] bx;
        ax = {1'b0, a};
        bx = {1'b0, b};
        return op ? ax - bx : ax + bx;
    endfunction

    // Requester driver: presents the head of each queue, drops it once it was accepted.
    always @(posedge clk) begin
        #1;
        if (drv_en) begin
            if (acc0 && rq0.size() > 0) void'(rq0.pop_front());
            if (acc1 && rq1.size() > 0) void'(rq1.pop_front());
            acc0 = 1'b0;
            acc1 = 1'b0;
            r0_valid = (rq0.size() > 0);
            {r0_op, r0_a, r0_b} = r0_valid ? rq0[0] : 9'd0;
            r1_valid = (rq1.size() > 0);
            {r1_op, r1_a, r1_b} = r1_valid ? rq1[0] : 9'd0;
        end
    end

    // Monitor and model, sampled on the falling edge.
    always @(negedge clk) begin
        logic       e0, e1, exp_rv, id;
        logic [5:0] e;
        if (!rst_n) begin
            check("rst_r0_ready", 32'(r0_ready), 32'd0);
            check("rst_r1_ready", 32'(r1_ready), 32'd0);
            check("rst_res_valid", 32'(res_valid), 32'd0);
            check("rst_res_id", 32'(res_id), 32'd0);
            check("rst_res_q", 32'(res_q), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_op_cnt", 32'(op_cnt), 32'd0);
            m_busy = 1'b0;
            m_age  = 0;
            m_last = 1'b1;
            m_cnt  = '0;
            acc0   = 1'b0;
            acc1   = 1'b0;
            sb.delete();
        end else begin
            if (m_busy) m_age++;
            exp_rv = m_busy && (m_age >= 2);
            check("res_valid", 32'(res_valid), 32'(exp_rv));
            check("busy", 32'(busy), 32'(m_busy));
            e0 = !m_busy && r0_valid && (!r1_valid || m_last);
            e1 = !m_busy && r1_valid && (!r0_valid || !m_last);
            check("r0_ready", 32'(r0_ready), 32'(e0));
            check("r1_ready", 32'(r1_ready), 32'(e1));
            acc0 = r0_valid && r0_ready;
            acc1 = r1_valid && r1_ready;
            if (exp_rv && res_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("res_id", 32'(res_id), 32'(e[5]));
                    check("res_q", 32'(res_q), 32'(e[4:0]));
                    check("op_cnt", 32'(op_cnt), 32'(m_cnt));
                    last_q  = res_q;
                    last_id = res_id;
                    m_cnt   = m_cnt + 8'd1;
                    m_last  = e[5];
                    m_busy  = 1'b0;
                end
            end else if (!m_busy && (acc0 || acc1)) begin
                id = !acc0;
                if (id) sb.push_back({1'b1, exp_res(r1_op, r1_a, r1_b)});
                else    sb.push_back({1'b0, exp_res(r0_op, r0_a, r0_b)});
                glog.push_back(id);
                m_busy = 1'b1;
                m_age  = 0;
            end
        end
    end

    task automatic do_reset();
        drv_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            {r0_valid, r0_op, r0_a, r0_b} = 10'($urandom);
            {r1_valid, r1_op, r1_a, r1_b} = 10'($urandom);
            res_ready = 1'($urandom);
        end
        rst_n     = 1'b1;
        r0_valid  = 1'b0;
        r1_valid  = 1'b0;
        res_ready = 1'b1;
        drv_en    = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (rq0.size() == 0 && rq1.size() == 0 && !m_busy && sb.size() == 0) break;
        end
        if (k == budget) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int k;
        // Reset with random inputs, then idle.
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        check("t1_idle_busy", 32'(busy), 32'd0);

        // Single add from r0.
        rq0.push_back('{OP_ADD, 4'd3, 4'd5});
        drain("t2", 50);
        check("t2_q", 32'(last_q), 32'd8);
        check("t2_id", 32'(last_id), 32'd0);
        check("t2_cnt", 32'(op_cnt), 32'd1);

        // Two subtracts from r1, the second one wrapping.
        rq1.push_back('{OP_SUB, 4'd10, 4'd5});
        rq1.push_back('{OP_SUB, 4'd1, 4'd2});
        drain("t3", 50);
        check("t3_q", 32'(last_q), 32'd31);
        check("t3_id", 32'(last_id), 32'd1);

        // Both requesters contending for four operations.
        glog.delete();
        for (int i = 1; i <= 2; i++) begin
            rq0.push_back('{OP_ADD, 4'(i), 4'(i)});
            rq1.push_back('{OP_SUB, 4'(2 * i), 4'(i)});
        end
        drain("t4", 100);
        check("t4_ngrants", 32'(glog.size()), 32'd4);
        if (glog.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t4_grant", 32'(glog[i]), 32'(i % 2));
        end

        // Back-pressure on the result with r1 waiting.
        glog.delete();
        res_ready = 1'b0;
        rq0.push_back('{OP_ADD, 4'd14, 4'd1});
        rq0.push_back('{OP_ADD, 4'd6, 4'd6});
        rq1.push_back('{OP_ADD, 4'd2, 4'd3});
        for (k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (res_valid) break;
        end
        if (k == 30) check("t5_rv_timeout", 32'd0, 32'd1);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("t5_hold_q", 32'(res_q), 32'd15);
            check("t5_hold_busy", 32'(busy), 32'd1);
            check("t5_hold_r1_ready", 32'(r1_ready), 32'd0);
        end
        res_ready = 1'b1;
        drain("t5", 100);
        check("t5_ngrants", 32'(glog.size()), 32'd3);
        if (glog.size() == 3) check("t5_next_grant", 32'(glog[1]), 32'd1);

        // Reset during EXEC discards the operation.
        rq0.push_back('{OP_ADD, 4'd7, 4'd3});
        for (k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (busy) break;
        end
        if (k == 30) check("t6_busy_timeout", 32'd0, 32'd1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t6_cnt_rst", 32'(op_cnt), 32'd0);
        glog.delete();
        rq0.push_back('{OP_ADD, 4'd1, 4'd0});
        rq1.push_back('{OP_ADD, 4'd2, 4'd0});
        drain("t6", 50);
        check("t6_ngrants", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) check("t6_first_grant", 32'(glog[0]), 32'd0);
        check("t6_cnt", 32'(op_cnt), 32'd2);

        // Counter wrap after 256 operations.
        do_reset();
        for (int i = 0; i < 256; i++) rq0.push_back('{OP_ADD, 4'(i), 4'(i >> 4)});
        drain("t7", 2000);
        check("t7_wrap", 32'(op_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

endmodule
